// File: rtl/dense_psum_accum_pkg.sv
// Shared types and helpers for the dense psum accumulation buffer.
package dense_psum_accum_pkg;

  // Buffer control states.
  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StFlush,
    StDrain
  } psum_state_e;

  // Largest signed value of a bw-bit accumulator (bw <= 64), zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(input int unsigned bw);
    return (64'd1 << (bw - 1)) - 64'd1;
  endfunction

  // Smallest signed value of a bw-bit accumulator, sign-extended to 64 bits.
  function automatic logic [63:0] sat_min(input int unsigned bw);
    return ~sat_max(bw);
  endfunction

  // Low bit of lane idx inside a packed bus of w-bit lanes.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/dense_psum_lane.sv
// One accumulation column: local memory, two-stage read-modify-write with forwarding,
// optional saturation, and a registered drain read port.
module dense_psum_lane
  import dense_psum_accum_pkg::*;
#(
  parameter int unsigned PsumBw   = 32,
  parameter int unsigned AddrW    = 11,
  parameter bit          Saturate = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              first_pass_i,
  input  logic              in_valid_i,
  input  logic [AddrW-1:0]  in_addr_i,
  input  logic [PsumBw-1:0] in_psum_i,
  input  logic              drain_en_i,
  input  logic [AddrW-1:0]  drain_addr_i,
  output logic [PsumBw-1:0] drain_data_o
);

  localparam int unsigned Depth = 1 << AddrW;
  localparam logic [PsumBw-1:0] SatMax = PsumBw'(sat_max(PsumBw));
  localparam logic [PsumBw-1:0] SatMin = PsumBw'(sat_min(PsumBw));

  logic [PsumBw-1:0] mem_q [Depth];

  logic              s1_valid_q;
  logic [AddrW-1:0]  s1_addr_q;
  logic [PsumBw-1:0] s1_psum_q;
  logic [PsumBw-1:0] s1_rd_q;
  logic [PsumBw-1:0] drain_data_q;

  logic [PsumBw-1:0] base;
  logic [PsumBw:0]   wide;
  logic [PsumBw-1:0] sum;
  logic [PsumBw-1:0] rd_fwd;

  // S1 sum with overflow handling, and S0 read with forwarding of the in-flight S1 result.
  always_comb begin
    base = first_pass_i ? '0 : s1_rd_q;
    wide = {base[PsumBw-1], base} + {s1_psum_q[PsumBw-1], s1_psum_q};
    sum  = wide[PsumBw-1:0];
    // Sign bits disagree only when the two's complement add overflowed.
    if (Saturate && (wide[PsumBw] != wide[PsumBw-1])) begin
      sum = wide[PsumBw] ? SatMin : SatMax;
    end
    rd_fwd = (s1_valid_q && (s1_addr_q == in_addr_i)) ? sum : mem_q[in_addr_i];
  end

  // S0 pipeline register and drain read register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_psum_q    <= '0;
      s1_rd_q      <= '0;
      drain_data_q <= '0;
    end else begin
      s1_valid_q <= in_valid_i;
      if (in_valid_i) begin
        s1_addr_q <= in_addr_i;
        s1_psum_q <= in_psum_i;
        s1_rd_q   <= rd_fwd;
      end
      if (drain_en_i) begin
        drain_data_q <= mem_q[drain_addr_i];
      end
    end
  end

  // S1 write-back; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (s1_valid_q) begin
      mem_q[s1_addr_q] <= sum;
    end
  end

  assign drain_data_o = drain_data_q;

endmodule

// File: rtl/dense_psum_accum.sv
// Partial-sum accumulation buffer above the dense PE array: multi-pass accumulation
// into per-column memories, then a valid/ready drain of the finished tile row by row.
module dense_psum_accum
  import dense_psum_accum_pkg::*;
#(
  parameter int unsigned NUM_COLS  = 32,
  parameter int unsigned PSUM_BW   = 32,
  parameter int unsigned ADDR_PSUM = 11,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          first_pass,
  input  logic                          last_pass,
  input  logic [ADDR_PSUM:0]            num_addr,
  input  logic                          pass_end,
  input  logic [NUM_COLS-1:0]           in_valid,
  input  logic [PSUM_BW*NUM_COLS-1:0]   psum_rows,
  input  logic [ADDR_PSUM*NUM_COLS-1:0] psum_addrs,
  output logic                          busy,
  output logic                          done,
  output logic                          addr_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PSUM_BW*NUM_COLS-1:0]   out_data,
  output logic [ADDR_PSUM-1:0]          out_addr,
  output logic                          out_last
);

  localparam logic [ADDR_PSUM-1:0] AddrOne = {{(ADDR_PSUM - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_PSUM:0]   NumOne  = {{ADDR_PSUM{1'b0}}, 1'b1};

  psum_state_e          state_q;
  logic                 first_q;
  logic                 last_q;
  logic [ADDR_PSUM:0]   num_q;
  logic                 flush_q;
  logic                 done_q;
  logic                 err_q;
  logic                 out_valid_q;
  logic [ADDR_PSUM-1:0] out_addr_q;
  logic                 out_last_q;

  logic [NUM_COLS-1:0]  in_range;
  logic [NUM_COLS-1:0]  lane_wr;
  logic                 err_hit;
  logic                 drain_first;
  logic                 drain_adv;
  logic                 drain_en;
  logic [ADDR_PSUM-1:0] drain_addr;
  logic                 next_last;

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
    localparam int unsigned DLo = slice_lo(c, PSUM_BW);
    localparam int unsigned ALo = slice_lo(c, ADDR_PSUM);

    logic [ADDR_PSUM-1:0] lane_addr;
    assign lane_addr   = psum_addrs[ALo +: ADDR_PSUM];
    assign in_range[c] = ({1'b0, lane_addr} < num_q);

    dense_psum_lane #(
      .PsumBw  (PSUM_BW),
      .AddrW   (ADDR_PSUM),
      .Saturate(SATURATE)
    ) u_lane (
      .clk_i       (clk),
      .rst_i       (reset),
      .first_pass_i(first_q),
      .in_valid_i  (lane_wr[c]),
      .in_addr_i   (lane_addr),
      .in_psum_i   (psum_rows[DLo +: PSUM_BW]),
      .drain_en_i  (drain_en),
      .drain_addr_i(drain_addr),
      .drain_data_o(out_data[DLo +: PSUM_BW])
    );
  end

  // Input acceptance, error detection and drain read scheduling.
  always_comb begin
    lane_wr     = (state_q == StAccum) ? (in_valid & in_range) : '0;
    err_hit     = (state_q == StAccum) && |(in_valid & ~in_range);
    // First drain read is issued as the flush ends so beat 0 is valid on entry to drain.
    drain_first = (state_q == StFlush) && flush_q && last_q;
    drain_adv   = (state_q == StDrain) && out_valid_q && out_ready && !out_last_q;
    drain_en    = drain_first || drain_adv;
    drain_addr  = drain_first ? '0 : (out_addr_q + AddrOne);
    next_last   = ({1'b0, drain_addr} == (num_q - NumOne));
  end

  // Control FSM with registered status and drain outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      num_q       <= '0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StAccum;
            first_q <= first_pass;
            last_q  <= last_pass;
            num_q   <= num_addr;
            err_q   <= 1'b0;
          end
        end
        StAccum: begin
          if (err_hit) begin
            err_q <= 1'b1;
          end
          if (pass_end) begin
            state_q <= StFlush;
            flush_q <= 1'b0;
          end
        end
        StFlush: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            if (last_q) begin
              state_q     <= StDrain;
              out_valid_q <= 1'b1;
              out_addr_q  <= drain_addr;
              out_last_q  <= next_last;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_q     <= StIdle;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              out_addr_q <= drain_addr;
              out_last_q <= next_last;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign addr_err  = err_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dense_psum_accum.sv
// Bench: one saturating and one wrapping instance driven in lockstep, compared with an
// array-based accumulation model.
module tb_dense_psum_accum;

  localparam int unsigned NC    = 4;
  localparam int unsigned BW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic first_pass = 1'b0;
  logic last_pass = 1'b0;
  logic pass_end = 1'b0;
  logic out_ready = 1'b0;
  logic [AW:0]       num_addr = '0;
  logic [NC-1:0]     in_valid = '0;
  logic [NC*BW-1:0]  psum_rows = '0;
  logic [NC*AW-1:0]  psum_addrs = '0;

  logic busy_s, done_s, err_s, ov_s, last_s;
  logic busy_w, done_w, err_w, ov_w, last_w;
  logic [NC*BW-1:0] data_s, data_w;
  logic [AW-1:0]    addr_s, addr_w;

  dense_psum_accum #(.NUM_COLS(NC), .PSUM_BW(BW), .ADDR_PSUM(AW), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .first_pass(first_pass), .last_pass(last_pass),
    .num_addr(num_addr), .pass_end(pass_end), .in_valid(in_valid), .psum_rows(psum_rows),
    .psum_addrs(psum_addrs), .busy(busy_s), .done(done_s), .addr_err(err_s),
    .out_valid(ov_s), .out_ready(out_ready), .out_data(data_s), .out_addr(addr_s),
    .out_last(last_s)
  );

  dense_psum_accum #(.NUM_COLS(NC), .PSUM_BW(BW), .ADDR_PSUM(AW), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .reset(reset), .start(start), .first_pass(first_pass), .last_pass(last_pass),
    .num_addr(num_addr), .pass_end(pass_end), .in_valid(in_valid), .psum_rows(psum_rows),
    .psum_addrs(psum_addrs), .busy(busy_w), .done(done_w), .addr_err(err_w),
    .out_valid(ov_w), .out_ready(out_ready), .out_data(data_w), .out_addr(addr_w),
    .out_last(last_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference memories for the two overflow modes.
  logic [BW-1:0] m_sat  [NC][DEPTH];
  logic [BW-1:0] m_wrap [NC][DEPTH];
  bit cur_first, cur_last, exp_err;
  int cur_num;
  int ready_mode;

  // Beat stimulus staging.
  logic [NC-1:0] sv;
  logic [AW-1:0] sa [NC];
  logic [BW-1:0] sd [NC];

  task automatic chk(input string tag, input logic [NC*BW-1:0] got, input logic [NC*BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] acc(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                        input bit sat);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (sat && s > 64'sd2147483647) s = 64'sd2147483647;
    if (sat && s < -64'sd2147483648) s = -64'sd2147483648;
    return BW'(s);
  endfunction

  function automatic logic [NC*BW-1:0] exp_row(input bit sat, input int a);
    logic [NC*BW-1:0] r;
    for (int c = 0; c < NC; c++) r[c*BW +: BW] = sat ? m_sat[c][a] : m_wrap[c][a];
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_val();
    if ($urandom_range(0, 3) == 0) return BW'($urandom);
    return BW'(int'($urandom_range(0, 400)) - 200);
  endfunction

  task automatic start_pass(input bit first, input bit last, input int num);
    first_pass = first;
    last_pass  = last;
    num_addr   = (AW + 1)'(num);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cur_first = first; cur_last = last; cur_num = num; exp_err = 1'b0;
    chk("busy_after_start", {busy_s, busy_w}, 2'b11);
    chk("err_cleared", {err_s, err_w}, 2'b00);
  endtask

  task automatic drive_beat();
    for (int c = 0; c < NC; c++) begin
      psum_rows[c*BW +: BW]  = sd[c];
      psum_addrs[c*AW +: AW] = sa[c];
      if (sv[c]) begin
        if (int'(sa[c]) >= cur_num) exp_err = 1'b1;
        else if (cur_first) begin
          m_sat[c][sa[c]] = sd[c];
          m_wrap[c][sa[c]] = sd[c];
        end else begin
          m_sat[c][sa[c]] = acc(m_sat[c][sa[c]], sd[c], 1'b1);
          m_wrap[c][sa[c]] = acc(m_wrap[c][sa[c]], sd[c], 1'b0);
        end
      end
    end
    in_valid = sv;
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic beat_all(input int a, input logic [BW-1:0] v);
    sv = '1;
    for (int c = 0; c < NC; c++) begin sa[c] = AW'(a); sd[c] = v; end
    drive_beat();
  endtask

  task automatic init_pass(input int num, input bit last);
    start_pass(1'b1, last, num);
    for (int i = 0; i < num; i++) begin
      sv = '1;
      for (int c = 0; c < NC; c++) begin sa[c] = AW'(i); sd[c] = rand_val(); end
      drive_beat();
    end
  endtask

  task automatic drain();
    int idx = 0, hs = 0, k = 0;
    bit fin = 1'b0, rdy, was_v;
    logic [3:0] pat = 4'b1001;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      was_v = ov_s;
      if (ov_s) begin
        chk("out_addr", addr_s, idx);
        chk("out_addr_wrap", addr_w, idx);
        chk("out_valid_wrap", ov_w, 1'b1);
        chk("out_data_sat", data_s, exp_row(1'b1, idx));
        chk("out_data_wrap", data_w, exp_row(1'b0, idx));
        chk("out_last", last_s, (idx == cur_num - 1));
        case (ready_mode)
          0: rdy = 1'b1;
          1: rdy = pat[k % 4];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        k++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      out_ready = rdy;
      @(posedge clk); #1;
      if (was_v && rdy) begin
        hs++;
        if (idx == cur_num - 1) fin = 1'b1;
        idx++;
      end
    end
    out_ready = 1'b0;
    chk("drain_handshakes", hs, cur_num);
    chk("drain_done", {done_s, done_w}, 2'b11);
    chk("drain_idle", {busy_s, busy_w, ov_s, ov_w}, 4'b0000);
    @(posedge clk); #1;
    chk("done_one_cycle", {done_s, done_w}, 2'b00);
  endtask

  task automatic end_pass();
    bit got_done = 1'b0;
    sv = '0;
    pass_end = 1'b1;
    @(posedge clk); #1;
    pass_end = 1'b0;
    chk("addr_err", {err_s, err_w}, {exp_err, exp_err});
    if (cur_last) begin
      drain();
    end else begin
      for (int cyc = 0; cyc < 10 && !got_done; cyc++) begin
        @(posedge clk); #1;
        chk("no_valid_mid_pass", {ov_s, ov_w}, 2'b00);
        got_done = done_s;
      end
      chk("pass_done", {done_s, done_w, busy_s, busy_w}, 4'b1100);
      @(posedge clk); #1;
      chk("done_one_cycle", {done_s, done_w}, 2'b00);
    end
  endtask

  initial begin
    #1;
    chk("reset_ctl", {busy_s, done_s, err_s, ov_s, last_s, busy_w, ov_w}, 7'b0);
    chk("reset_data", data_s, '0);
    chk("reset_addr", addr_s, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // pass_end outside ACCUM does nothing.
    pass_end = 1'b1;
    @(posedge clk); #1;
    pass_end = 1'b0;
    chk("pass_end_idle", {busy_s, busy_w}, 2'b00);

    // Single pass: col0 5..8.
    ready_mode = 0;
    start_pass(1'b1, 1'b1, 4);
    for (int i = 0; i < 4; i++) begin
      sv = '1;
      for (int c = 0; c < NC; c++) begin sa[c] = AW'(i); sd[c] = (c == 0) ? BW'(5 + i) : '0; end
      drive_beat();
    end
    end_pass();

    // Three passes of +10 at addr 2.
    start_pass(1'b1, 1'b0, 4);
    for (int i = 0; i < 4; i++) beat_all(i, (i == 2) ? 32'd10 : 32'd0);
    end_pass();
    start_pass(1'b0, 1'b0, 4); beat_all(2, 32'd10); end_pass();
    start_pass(1'b0, 1'b1, 4); beat_all(2, 32'd10); end_pass();

    // Back-to-back hazard on col3 addr 7.
    start_pass(1'b1, 1'b0, 8);
    for (int i = 0; i < 8; i++) beat_all(i, 32'd0);
    end_pass();
    start_pass(1'b0, 1'b1, 8);
    for (int i = 0; i < 4; i++) begin
      sv = 4'b1000;
      for (int c = 0; c < NC; c++) begin sa[c] = AW'(7); sd[c] = 32'd1; end
      drive_beat();
    end
    end_pass();

    // Overflow in both directions plus an exact fit.
    ready_mode = 2;
    start_pass(1'b1, 1'b0, 1);
    sv = '1;
    for (int c = 0; c < NC; c++) sa[c] = '0;
    sd[0] = 32'h7FFF_FFF0; sd[1] = 32'h8000_0010; sd[2] = 32'h7FFF_FFF0; sd[3] = 32'd5;
    drive_beat();
    end_pass();
    start_pass(1'b0, 1'b1, 1);
    sv = '1;
    sd[0] = 32'h20; sd[1] = 32'hFFFF_FFE0; sd[2] = 32'h0F; sd[3] = 32'd7;
    drive_beat();
    end_pass();

    // Backpressure 1,0,0,1 on a 3-entry drain.
    ready_mode = 1;
    init_pass(3, 1'b1);
    end_pass();

    // Out-of-range address is dropped and flagged.
    ready_mode = 0;
    init_pass(16, 1'b0);
    end_pass();
    start_pass(1'b0, 1'b0, 8);
    sv = 4'b0011;
    sa[0] = AW'(9); sd[0] = 32'd100; sa[1] = AW'(3); sd[1] = 32'd1;
    sa[2] = '0; sd[2] = '0; sa[3] = '0; sd[3] = '0;
    drive_beat();
    end_pass();
    start_pass(1'b0, 1'b1, 16);
    end_pass();

    // Randomised multi-pass rounds.
    for (int r = 0; r < 6; r++) begin
      int n, np;
      ready_mode = 2;
      n  = $urandom_range(1, DEPTH);
      np = $urandom_range(1, 3);
      init_pass(n, 1'b0);
      end_pass();
      for (int p = 0; p < np; p++) begin
        start_pass(1'b0, (p == np - 1), n);
        for (int b = 0; b < int'($urandom_range(1, 24)); b++) begin
          sv = ($urandom_range(0, 4) == 0) ? '0 : NC'($urandom);
          for (int c = 0; c < NC; c++) begin
            sa[c] = AW'($urandom_range(0, (n < DEPTH) ? n : DEPTH - 1));
            sd[c] = rand_val();
          end
          drive_beat();
        end
        end_pass();
      end
    end

    // Reset during drain aborts at once.
    init_pass(4, 1'b1);
    out_ready = 1'b0;
    pass_end = 1'b1;
    @(posedge clk); #1;
    pass_end = 1'b0;
    for (int cyc = 0; cyc < 10 && !ov_s; cyc++) begin @(posedge clk); #1; end
    chk("reached_drain", {ov_s, ov_w}, 2'b11);
    reset = 1'b1;
    #1;
    chk("reset_abort_ctl", {ov_s, busy_s, ov_w, busy_w, done_s, last_s}, 6'b0);
    chk("reset_abort_data", data_s, '0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fresh pass after the abort.
    ready_mode = 0;
    init_pass(2, 1'b1);
    end_pass();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_psum_accum.md
Name: dense_psum_accum

Overview:
- Parametrised partial-sum accumulation buffer that sits directly above the dense PE array's top row.
- Captures per-column psum/address pairs over multiple input-channel passes and accumulates them in per-column local memories using a read-modify-write pipeline with forwarding.
- After the final pass it drains the accumulated tile row-by-row over a valid/ready stream toward quantization/AXI.
- Generalises the array's raw psum outputs with column count, depth, saturation and multi-pass modes.

Parameters:
- NUM_COLS, 32, number of PE columns (independent accumulation lanes)
- PSUM_BW, 32, psum/accumulator width (two's complement)
- ADDR_PSUM, 11, psum address width; per-column depth = 2^ADDR_PSUM
- SATURATE, 1, 1 = clamp to signed PSUM_BW range on overflow; 0 = wrap

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse in IDLE: begin a pass
- first_pass  in  1  sampled with start: overwrite instead of accumulate
- last_pass  in  1  sampled with start: drain after this pass
- num_addr  in  ADDR_PSUM+1  valid entries (1..2^ADDR_PSUM), sampled with start
- pass_end  in  1  pulse in ACCUM: no more inputs for this pass
- in_valid  in  NUM_COLS  per-column psum valid
- psum_rows  in  PSUM_BW*NUM_COLS  column c at bits [PSUM_BW*(c+1)-1 : PSUM_BW*c]
- psum_addrs  in  ADDR_PSUM*NUM_COLS  per-column address, same packing
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at end of pass (non-last) or end of drain
- addr_err  out  1  sticky: a valid input had addr >= num_addr; cleared by start
- out_valid  out  1  drain data valid
- out_ready  in  1  downstream accepts
- out_data  out  PSUM_BW*NUM_COLS  all columns at out_addr
- out_addr  out  ADDR_PSUM  drained address
- out_last  out  1  high with the final drained beat

Behaviour:
- Reset: state = IDLE; busy, done, addr_err, out_valid and out_last = 0; out_data and out_addr = 0. Memory contents are undefined.
- Reset mid-operation aborts immediately; no partial drain.
- FSM: IDLE -start-> ACCUM; ACCUM -pass_end-> FLUSH; FLUSH (2 cycles, pipeline empties) -> DRAIN if last_pass, else IDLE with done. DRAIN -handshake with out_last-> IDLE with done.
- start outside IDLE and pass_end outside ACCUM are ignored.
- Pipeline, per column:
  - S0: read mem[addr], register data/addr/valid.
  - S1: sum = (first_pass ? 0 : rd) + psum; write mem[addr] = sum.
  - Throughput 1 psum/column/cycle; write latency 2 cycles.
- Hazards:
  - If the S0 addr equals the S1 addr in the same column, the S1 sum is forwarded in place of the memory read.
  - Repeated address in consecutive cycles must accumulate exactly.
- Overflow: SATURATE=1 clamps to 2^(PSUM_BW-1)-1 or -2^(PSUM_BW-1); SATURATE=0 wraps modulo 2^PSUM_BW.
- Inputs with addr >= num_addr are dropped (no write) and set addr_err.
- in_valid outside ACCUM is ignored.
- Drain:
  - Address counter runs 0..num_addr-1; memory read latency 1.
  - out_valid is held with out_data/out_addr stable until out_ready; there are no bubbles while out_ready stays high.
  - out_last accompanies addr num_addr-1.
  - out_ready high while out_valid is low has no effect.
- Drain reads are not modified; a subsequent first_pass overwrites entries.

Decomposition:
- Shared package: psum state encoding (IDLE/ACCUM/FLUSH/DRAIN), saturation min/max constants as functions of PSUM_BW, and the packed-slice index helper.
- Sub-module: dense_psum_lane (one column: memory, S0/S1 RMW, forwarding, saturation), instantiated NUM_COLS times by generate.
- Top level holds the FSM, drain counter, addr_err and output registering.

Test Plan:
- Single pass with first_pass=1, last_pass=1, num_addr=4: col0 writes 5,6,7,8 at addr 0..3 → drain beats out_addr 0..3 with col0 = 5,6,7,8; out_last on beat 3; done pulses once.
- Three passes of +10 at addr 2 on all columns (first, mid, last) → drained addr 2 = 30 in every column; non-last passes pulse done without out_valid.
- Back-to-back hazard: col3 writes +1 to addr 7 on 4 consecutive cycles after first_pass → drained value 4.
- Overflow: accumulate 0x7FFFFFF0 + 0x20 → SATURATE=1 gives 0x7FFFFFFF; SATURATE=0 gives 0x80000010.
- Backpressure: toggle out_ready 1,0,0,1 during a num_addr=3 drain → out_data/out_addr stable while stalled; exactly 3 handshakes, in order.
- Error/reset: addr 9 with num_addr=8 → addr_err=1 and no write; assert reset during DRAIN → out_valid=0, busy=0 in the same cycle.
